instr_decode_queue: RTL and testbench

//  Parametrised RV32I(+M) decode stage with built-in FIFO, between fetch and issue.

---
 rtl/instr_decode_queue_pkg.sv | 61 ++++++
 rtl/instr_decode_queue_if.sv | 35 +++
 rtl/instr_decode_queue_decoder.sv | 129 ++++++++++++
 rtl/instr_decode_queue.sv | 67 ++++++
 tb/tb_instr_decode_queue.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_decode_queue_pkg.sv
// Shared RV32I(+M) decode types: opcode constants, decoded instruction/opcode enums
// and the decoded_entry_t record stored by the queue.
package instr_decode_queue_pkg;

  localparam logic [6:0] RV_LUI      = 7'b0110111;
  localparam logic [6:0] RV_AUIPC    = 7'b0010111;
  localparam logic [6:0] RV_JAL      = 7'b1101111;
  localparam logic [6:0] RV_JALR     = 7'b1100111;
  localparam logic [6:0] RV_BRANCH   = 7'b1100011;
  localparam logic [6:0] RV_LOAD     = 7'b0000011;
  localparam logic [6:0] RV_STORE    = 7'b0100011;
  localparam logic [6:0] RV_OP_IMM   = 7'b0010011;
  localparam logic [6:0] RV_OP       = 7'b0110011;
  localparam logic [6:0] RV_MISC_MEM = 7'b0001111;
  localparam logic [6:0] RV_SYSTEM   = 7'b1110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [5:0] {
    INSTR_NO_OP, INSTR_BAD_INSTR,
    INSTR_LUI, INSTR_AUIPC, INSTR_JAL, INSTR_JALR,
    INSTR_BEQ, INSTR_BNE, INSTR_BLT, INSTR_BGE, INSTR_BLTU, INSTR_BGEU,
    INSTR_LB, INSTR_LH, INSTR_LW, INSTR_LBU, INSTR_LHU,
    INSTR_SB, INSTR_SH, INSTR_SW,
    INSTR_ADDI, INSTR_SLTI, INSTR_SLTIU, INSTR_XORI, INSTR_ORI, INSTR_ANDI,
    INSTR_SLLI, INSTR_SRLI, INSTR_SRAI,
    INSTR_ADD, INSTR_SUB, INSTR_SLL, INSTR_SLT, INSTR_SLTU, INSTR_XOR,
    INSTR_SRL, INSTR_SRA, INSTR_OR, INSTR_AND,
    INSTR_MUL, INSTR_MULH, INSTR_MULHSU, INSTR_MULHU,
    INSTR_DIV, INSTR_DIVU, INSTR_REM, INSTR_REMU,
    INSTR_FENCE, INSTR_FENCE_I, INSTR_ECALL, INSTR_EBREAK
  } instr_e;

  typedef enum logic [3:0] {
    OP_NO_OP, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
    OP_LOAD, OP_STORE, OP_COMP_IMM, OP_COMP, OP_SYSTEM
  } opcode_e;

  typedef struct packed {
    instr_e      instr;
    opcode_e     opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        illegal;
  } decoded_entry_t;

  localparam decoded_entry_t NOP_ENTRY = '{
    instr: INSTR_NO_OP, opcode: OP_NO_OP, rd: 5'd0, rs1: 5'd0, rs2: 5'd0,
    imm: 32'd0, illegal: 1'b0
  };

  localparam decoded_entry_t BAD_ENTRY = '{
    instr: INSTR_BAD_INSTR, opcode: OP_NO_OP, rd: 5'd0, rs1: 5'd0, rs2: 5'd0,
    imm: 32'd0, illegal: 1'b1
  };

endpackage

// File: rtl/instr_decode_queue_if.sv
// Fetch-side push and issue-side pop handshakes of the decode queue, plus occupancy.
interface instr_decode_queue_if #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
);
  import instr_decode_queue_pkg::*;

  logic                     in_valid;
  logic                     in_ready;
  logic [31:0]              in_instr;
  logic [PC_W-1:0]          in_pc;
  logic                     out_valid;
  logic                     out_ready;
  instr_e                   out_instr;
  opcode_e                  out_opcode;
  logic [4:0]               out_rd;
  logic [4:0]               out_rs1;
  logic [4:0]               out_rs2;
  logic [31:0]              out_imm;
  logic [PC_W-1:0]          out_pc;
  logic                     out_illegal;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_opcode, out_rd, out_rs1, out_rs2,
           out_imm, out_pc, out_illegal, count
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_opcode, out_rd, out_rs1, out_rs2,
           out_imm, out_pc, out_illegal, count
  );
endinterface

// File: rtl/instr_decode_queue_decoder.sv
// Combinational RV32I(+M) word decoder; any unrecognised encoding collapses to BAD_ENTRY
// so that illegal words never leak register indices or immediates downstream.
module instr_decoder
  import instr_decode_queue_pkg::*;
#(
  parameter int M_EXT = 1
) (
  input  logic [31:0]    word,
  output decoded_entry_t dec
);
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  decoded_entry_t raw;

  assign opc   = word[6:0];
  assign f3    = word[14:12];
  assign f7    = word[31:25];
  assign imm_i = {{20{word[31]}}, word[31:20]};
  assign imm_s = {{20{word[31]}}, word[31:25], word[11:7]};
  assign imm_b = {{19{word[31]}}, word[31], word[7], word[30:25], word[11:8], 1'b0};
  assign imm_u = {word[31:12], 12'd0};
  assign imm_j = {{11{word[31]}}, word[31], word[19:12], word[20], word[30:21], 1'b0};

  always_comb begin
    raw = NOP_ENTRY;
    raw.instr = INSTR_BAD_INSTR;
    case (opc)
      RV_LUI:   begin raw.instr = INSTR_LUI;   raw.opcode = OP_LUI;   raw.rd = word[11:7]; raw.imm = imm_u; end
      RV_AUIPC: begin raw.instr = INSTR_AUIPC; raw.opcode = OP_AUIPC; raw.rd = word[11:7]; raw.imm = imm_u; end
      RV_JAL:   begin raw.instr = INSTR_JAL;   raw.opcode = OP_JAL;   raw.rd = word[11:7]; raw.imm = imm_j; end
      RV_JALR: begin
        raw.opcode = OP_JALR; raw.rd = word[11:7]; raw.rs1 = word[19:15]; raw.imm = imm_i;
        if (f3 == 3'd0) raw.instr = INSTR_JALR;
      end
      RV_BRANCH: begin
        raw.opcode = OP_BRANCH; raw.rs1 = word[19:15]; raw.rs2 = word[24:20]; raw.imm = imm_b;
        case (f3)
          3'd0: raw.instr = INSTR_BEQ;
          3'd1: raw.instr = INSTR_BNE;
          3'd4: raw.instr = INSTR_BLT;
          3'd5: raw.instr = INSTR_BGE;
          3'd6: raw.instr = INSTR_BLTU;
          3'd7: raw.instr = INSTR_BGEU;
          default: raw.instr = INSTR_BAD_INSTR;
        endcase
      end
      RV_LOAD: begin
        raw.opcode = OP_LOAD; raw.rd = word[11:7]; raw.rs1 = word[19:15]; raw.imm = imm_i;
        case (f3)
          3'd0: raw.instr = INSTR_LB;
          3'd1: raw.instr = INSTR_LH;
          3'd2: raw.instr = INSTR_LW;
          3'd4: raw.instr = INSTR_LBU;
          3'd5: raw.instr = INSTR_LHU;
          default: raw.instr = INSTR_BAD_INSTR;
        endcase
      end
      RV_STORE: begin
        raw.opcode = OP_STORE; raw.rs1 = word[19:15]; raw.rs2 = word[24:20]; raw.imm = imm_s;
        case (f3)
          3'd0: raw.instr = INSTR_SB;
          3'd1: raw.instr = INSTR_SH;
          3'd2: raw.instr = INSTR_SW;
          default: raw.instr = INSTR_BAD_INSTR;
        endcase
      end
      RV_OP_IMM: begin
        raw.opcode = OP_COMP_IMM; raw.rd = word[11:7]; raw.rs1 = word[19:15]; raw.imm = imm_i;
        case (f3)
          3'd0: raw.instr = INSTR_ADDI;
          3'd2: raw.instr = INSTR_SLTI;
          3'd3: raw.instr = INSTR_SLTIU;
          3'd4: raw.instr = INSTR_XORI;
          3'd6: raw.instr = INSTR_ORI;
          3'd7: raw.instr = INSTR_ANDI;
          // shift-immediates reuse the funct7 slot, so it must be a legal shift kind
          3'd1: raw.instr = (f7 == F7_BASE) ? INSTR_SLLI : INSTR_BAD_INSTR;
          3'd5: raw.instr = (f7 == F7_BASE) ? INSTR_SRLI :
                            (f7 == F7_ALT)  ? INSTR_SRAI : INSTR_BAD_INSTR;
          default: raw.instr = INSTR_BAD_INSTR;
        endcase
      end
      RV_OP: begin
        raw.opcode = OP_COMP; raw.rd = word[11:7]; raw.rs1 = word[19:15]; raw.rs2 = word[24:20];
        if (f7 == F7_BASE) begin
          case (f3)
            3'd0: raw.instr = INSTR_ADD;
            3'd1: raw.instr = INSTR_SLL;
            3'd2: raw.instr = INSTR_SLT;
            3'd3: raw.instr = INSTR_SLTU;
            3'd4: raw.instr = INSTR_XOR;
            3'd5: raw.instr = INSTR_SRL;
            3'd6: raw.instr = INSTR_OR;
            default: raw.instr = INSTR_AND;
          endcase
        end else if (f7 == F7_ALT) begin
          raw.instr = (f3 == 3'd0) ? INSTR_SUB :
                      (f3 == 3'd5) ? INSTR_SRA : INSTR_BAD_INSTR;
        end else if (f7 == F7_MULDIV && M_EXT != 0) begin
          case (f3)
            3'd0: raw.instr = INSTR_MUL;
            3'd1: raw.instr = INSTR_MULH;
            3'd2: raw.instr = INSTR_MULHSU;
            3'd3: raw.instr = INSTR_MULHU;
            3'd4: raw.instr = INSTR_DIV;
            3'd5: raw.instr = INSTR_DIVU;
            3'd6: raw.instr = INSTR_REM;
            default: raw.instr = INSTR_REMU;
          endcase
        end
      end
      // fences are ordering no-ops for this pipeline; operand fields are not carried
      RV_MISC_MEM: begin
        if (f3 == 3'd0) raw.instr = INSTR_FENCE;
        else if (f3 == 3'd1) raw.instr = INSTR_FENCE_I;
      end
      RV_SYSTEM: begin
        raw.opcode = OP_SYSTEM;
        if (word == 32'h0000_0073) raw.instr = INSTR_ECALL;
        else if (word == 32'h0010_0073) raw.instr = INSTR_EBREAK;
      end
      default: raw.instr = INSTR_BAD_INSTR;
    endcase
  end

  assign dec = (raw.instr == INSTR_BAD_INSTR) ? BAD_ENTRY : raw;
endmodule

// File: rtl/instr_decode_queue.sv
// Decode stage with a DEPTH-entry FIFO of decoded entries between fetch and issue.
// One cycle push-to-head latency; in_ready drops at full with no same-cycle pass-through.
module instr_decode_queue
  import instr_decode_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32,
  parameter int M_EXT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic flush_i,
  instr_decode_queue_if.slave q
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  decoded_entry_t  dec;
  decoded_entry_t  ent_mem [DEPTH];
  logic [PC_W-1:0] pc_mem  [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic push, pop;

  instr_decoder #(.M_EXT(M_EXT)) u_dec (.word(q.in_instr), .dec(dec));

  assign q.in_ready  = cnt < CNT_W'(DEPTH);
  assign q.out_valid = cnt != '0;
  assign q.count     = cnt;
  assign push = q.in_valid & q.in_ready;
  assign pop  = q.out_valid & q.out_ready;

  // Storage is reset too so the idle head reads as a clean NO_OP after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_mem[i] <= NOP_ENTRY;
        pc_mem[i]  <= '0;
      end
    end else if (flush_i) begin
      cnt    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        ent_mem[wr_ptr] <= dec;
        pc_mem[wr_ptr]  <= q.in_pc;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      cnt <= cnt + CNT_W'(1);
      else if (pop && !push) cnt <= cnt - CNT_W'(1);
    end
  end

  assign q.out_instr   = ent_mem[rd_ptr].instr;
  assign q.out_opcode  = ent_mem[rd_ptr].opcode;
  assign q.out_rd      = ent_mem[rd_ptr].rd;
  assign q.out_rs1     = ent_mem[rd_ptr].rs1;
  assign q.out_rs2     = ent_mem[rd_ptr].rs2;
  assign q.out_imm     = ent_mem[rd_ptr].imm;
  assign q.out_illegal = ent_mem[rd_ptr].illegal;
  assign q.out_pc      = pc_mem[rd_ptr];
endmodule

// File: tb/tb_instr_decode_queue.sv
// Two queues (M_EXT=1 and M_EXT=0) share one random stimulus stream and are scored
// against an encoding-table reference decoder plus a queue-based occupancy model.
module tb_instr_decode_queue;
  import instr_decode_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int PC_W  = 32;

  typedef struct packed {
    decoded_entry_t  d;
    logic [PC_W-1:0] pc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic v_in = 1'b0, rdy = 1'b0;
  logic [31:0] w_in = '0;
  logic [PC_W-1:0] pc_in = '0;

  always #5 clk = ~clk;

  instr_decode_queue_if #(.DEPTH(DEPTH), .PC_W(PC_W)) b1 ();
  instr_decode_queue_if #(.DEPTH(DEPTH), .PC_W(PC_W)) b0 ();

  assign b1.in_valid = v_in;  assign b0.in_valid = v_in;
  assign b1.in_instr = w_in;  assign b0.in_instr = w_in;
  assign b1.in_pc    = pc_in; assign b0.in_pc    = pc_in;
  assign b1.out_ready = rdy;  assign b0.out_ready = rdy;

  instr_decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .M_EXT(1)) dut1 (
    .clk(clk), .rst(rst), .flush_i(flush), .q(b1));
  instr_decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .M_EXT(0)) dut0 (
    .clk(clk), .rst(rst), .flush_i(flush), .q(b0));

  exp_t h1, h0;
  assign h1 = {b1.out_instr, b1.out_opcode, b1.out_rd, b1.out_rs1, b1.out_rs2,
               b1.out_imm, b1.out_illegal, b1.out_pc};
  assign h0 = {b0.out_instr, b0.out_opcode, b0.out_rd, b0.out_rs1, b0.out_rs2,
               b0.out_imm, b0.out_illegal, b0.out_pc};

  exp_t q1[$];
  exp_t q0[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference encoding table: mask/match pairs from the RISC-V opcode map.
  logic [31:0] t_mask[$];
  logic [31:0] t_match[$];
  instr_e      t_instr[$];
  opcode_e     t_op[$];
  byte         t_fmt[$];
  bit          t_mext[$];

  task automatic add(logic [31:0] m, logic [31:0] v, instr_e i, opcode_e o, byte f, bit mx);
    t_mask.push_back(m); t_match.push_back(v); t_instr.push_back(i);
    t_op.push_back(o); t_fmt.push_back(f); t_mext.push_back(mx);
  endtask

  task automatic build_table();
    add(32'h7F, 32'h37, INSTR_LUI, OP_LUI, "U", 0);
    add(32'h7F, 32'h17, INSTR_AUIPC, OP_AUIPC, "U", 0);
    add(32'h7F, 32'h6F, INSTR_JAL, OP_JAL, "J", 0);
    add(32'h707F, 32'h67, INSTR_JALR, OP_JALR, "I", 0);
    add(32'h707F, 32'h0063, INSTR_BEQ, OP_BRANCH, "B", 0);
    add(32'h707F, 32'h1063, INSTR_BNE, OP_BRANCH, "B", 0);
    add(32'h707F, 32'h4063, INSTR_BLT, OP_BRANCH, "B", 0);
    add(32'h707F, 32'h5063, INSTR_BGE, OP_BRANCH, "B", 0);
    add(32'h707F, 32'h6063, INSTR_BLTU, OP_BRANCH, "B", 0);
    add(32'h707F, 32'h7063, INSTR_BGEU, OP_BRANCH, "B", 0);
    add(32'h707F, 32'h0003, INSTR_LB, OP_LOAD, "I", 0);
    add(32'h707F, 32'h1003, INSTR_LH, OP_LOAD, "I", 0);
    add(32'h707F, 32'h2003, INSTR_LW, OP_LOAD, "I", 0);
    add(32'h707F, 32'h4003, INSTR_LBU, OP_LOAD, "I", 0);
    add(32'h707F, 32'h5003, INSTR_LHU, OP_LOAD, "I", 0);
    add(32'h707F, 32'h0023, INSTR_SB, OP_STORE, "S", 0);
    add(32'h707F, 32'h1023, INSTR_SH, OP_STORE, "S", 0);
    add(32'h707F, 32'h2023, INSTR_SW, OP_STORE, "S", 0);
    add(32'h707F, 32'h0013, INSTR_ADDI, OP_COMP_IMM, "I", 0);
    add(32'h707F, 32'h2013, INSTR_SLTI, OP_COMP_IMM, "I", 0);
    add(32'h707F, 32'h3013, INSTR_SLTIU, OP_COMP_IMM, "I", 0);
    add(32'h707F, 32'h4013, INSTR_XORI, OP_COMP_IMM, "I", 0);
    add(32'h707F, 32'h6013, INSTR_ORI, OP_COMP_IMM, "I", 0);
    add(32'h707F, 32'h7013, INSTR_ANDI, OP_COMP_IMM, "I", 0);
    add(32'hFE00707F, 32'h00001013, INSTR_SLLI, OP_COMP_IMM, "I", 0);
    add(32'hFE00707F, 32'h00005013, INSTR_SRLI, OP_COMP_IMM, "I", 0);
    add(32'hFE00707F, 32'h40005013, INSTR_SRAI, OP_COMP_IMM, "I", 0);
    add(32'hFE00707F, 32'h00000033, INSTR_ADD, OP_COMP, "R", 0);
    add(32'hFE00707F, 32'h40000033, INSTR_SUB, OP_COMP, "R", 0);
    add(32'hFE00707F, 32'h00001033, INSTR_SLL, OP_COMP, "R", 0);
    add(32'hFE00707F, 32'h00002033, INSTR_SLT, OP_COMP, "R", 0);
    add(32'hFE00707F, 32'h00003033, INSTR_SLTU, OP_COMP, "R", 0);
    add(32'hFE00707F, 32'h00004033, INSTR_XOR, OP_COMP, "R", 0);
    add(32'hFE00707F, 32'h00005033, INSTR_SRL, OP_COMP, "R", 0);
    add(32'hFE00707F, 32'h40005033, INSTR_SRA, OP_COMP, "R", 0);
    add(32'hFE00707F, 32'h00006033, INSTR_OR, OP_COMP, "R", 0);
    add(32'hFE00707F, 32'h00007033, INSTR_AND, OP_COMP, "R", 0);
    add(32'hFE00707F, 32'h02000033, INSTR_MUL, OP_COMP, "R", 1);
    add(32'hFE00707F, 32'h02001033, INSTR_MULH, OP_COMP, "R", 1);
    add(32'hFE00707F, 32'h02002033, INSTR_MULHSU, OP_COMP, "R", 1);
    add(32'hFE00707F, 32'h02003033, INSTR_MULHU, OP_COMP, "R", 1);
    add(32'hFE00707F, 32'h02004033, INSTR_DIV, OP_COMP, "R", 1);
    add(32'hFE00707F, 32'h02005033, INSTR_DIVU, OP_COMP, "R", 1);
    add(32'hFE00707F, 32'h02006033, INSTR_REM, OP_COMP, "R", 1);
    add(32'hFE00707F, 32'h02007033, INSTR_REMU, OP_COMP, "R", 1);
    add(32'h707F, 32'h000F, INSTR_FENCE, OP_NO_OP, "N", 0);
    add(32'h707F, 32'h100F, INSTR_FENCE_I, OP_NO_OP, "N", 0);
    add(32'hFFFFFFFF, 32'h00000073, INSTR_ECALL, OP_SYSTEM, "N", 0);
    add(32'hFFFFFFFF, 32'h00100073, INSTR_EBREAK, OP_SYSTEM, "N", 0);
  endtask

  function automatic decoded_entry_t ref_decode(logic [31:0] w, bit m);
    decoded_entry_t e;
    int hit = -1;
    logic [11:0] s12;
    logic [12:0] b13;
    logic [20:0] j21;
    for (int i = 0; i < t_mask.size(); i++)
      if ((w & t_mask[i]) == t_match[i] && (m || !t_mext[i])) hit = i;
    e = '0;
    e.instr = INSTR_BAD_INSTR;
    e.opcode = OP_NO_OP;
    e.illegal = 1'b1;
    if (hit < 0) return e;
    e.illegal = 1'b0;
    e.instr = t_instr[hit];
    e.opcode = t_op[hit];
    s12 = {w[31:25], w[11:7]};
    b13 = {w[31], w[7], w[30:25], w[11:8], 1'b0};
    j21 = {w[31], w[19:12], w[20], w[30:21], 1'b0};
    case (t_fmt[hit])
      "R": begin e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20]; end
      "I": begin e.rd = w[11:7]; e.rs1 = w[19:15]; e.imm = 32'($signed(w[31:20])); end
      "S": begin e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.imm = 32'($signed(s12)); end
      "B": begin e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.imm = 32'($signed(b13)); end
      "U": begin e.rd = w[11:7]; e.imm = w & 32'hFFFFF000; end
      "J": begin e.rd = w[11:7]; e.imm = 32'($signed(j21)); end
      default: ;
    endcase
    return e;
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Monitor: whenever a head is presented, it must equal the oldest expected entry.
  always @(negedge clk) begin
    #1;
    if (!rst && !flush) begin
      if (b1.out_valid) begin
        if (q1.size() == 0) chk("head_m1_unexpected", 128'(h1), 128'(0));
        else begin
          chk("head_m1", 128'(h1), 128'(q1[0]));
          if (b1.out_ready) void'(q1.pop_front());
        end
      end
      if (b0.out_valid) begin
        if (q0.size() == 0) chk("head_m0_unexpected", 128'(h0), 128'(0));
        else begin
          chk("head_m0", 128'(h0), 128'(q0[0]));
          if (b0.out_ready) void'(q0.pop_front());
        end
      end
    end
  end

  task automatic step(bit v, logic [31:0] w, logic [31:0] pc, bit r, bit f);
    v_in = v; w_in = w; pc_in = pc; rdy = r; flush = f;
    @(negedge clk);
    chk("count_m1", 128'(b1.count), 128'(q1.size()));
    chk("count_m0", 128'(b0.count), 128'(q0.size()));
    chk("in_ready", 128'(b1.in_ready), 128'(q1.size() < DEPTH));
    chk("out_valid", 128'(b1.out_valid), 128'(q1.size() != 0));
    if (f) begin
      q1.delete(); q0.delete();
    end else if (v && q1.size() < DEPTH) begin
      q1.push_back(exp_t'({ref_decode(w, 1'b1), pc}));
      q0.push_back(exp_t'({ref_decode(w, 1'b0), pc}));
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset(int cycles);
    rst = 1'b1; v_in = 1'b0; rdy = 1'b0; flush = 1'b0;
    repeat (cycles) @(posedge clk);
    #1 rst = 1'b0;
    q1.delete(); q0.delete();
    chk("rst_count", 128'(b1.count), 128'(0));
    chk("rst_out_valid", 128'(b1.out_valid), 128'(0));
    chk("rst_in_ready", 128'(b1.in_ready), 128'(1));
    chk("rst_head_m1", 128'(h1), 128'(exp_t'({NOP_ENTRY, 32'd0})));
    chk("rst_head_m0", 128'(h0), 128'(exp_t'({NOP_ENTRY, 32'd0})));
  endtask

  function automatic logic [31:0] gen_word();
    int k = $urandom_range(0, 9);
    int idx;
    if (k == 0) return $urandom;
    if (k == 1) return 32'hFFFFFFFF;
    idx = $urandom_range(0, t_mask.size() - 1);
    return ($urandom & ~t_mask[idx]) | t_match[idx];
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] pc;
    build_table();
    do_reset(2);

    step(1, 32'h00500093, 32'h100, 0, 0);
    chk("addi_fields", 128'({b1.out_valid, b1.out_instr, b1.out_opcode, b1.out_rd, b1.out_rs1, b1.out_imm, b1.out_pc}),
        128'({1'b1, INSTR_ADDI, OP_COMP_IMM, 5'd1, 5'd0, 32'd5, 32'h100}));
    step(0, 0, 0, 1, 0);

    step(1, 32'hFE208EE3, 32'h104, 0, 0);
    chk("beq_fields", 128'({b1.out_instr, b1.out_opcode, b1.out_rd, b1.out_rs1, b1.out_rs2, b1.out_imm}),
        128'({INSTR_BEQ, OP_BRANCH, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC}));
    step(0, 0, 0, 1, 0);

    step(1, 32'h022081B3, 32'h108, 0, 0);
    chk("mul_m1", 128'({b1.out_instr, b1.out_opcode, b1.out_illegal}), 128'({INSTR_MUL, OP_COMP, 1'b0}));
    chk("mul_m0", 128'({b0.out_instr, b0.out_illegal}), 128'({INSTR_BAD_INSTR, 1'b1}));
    step(0, 0, 0, 1, 0);

    step(1, 32'hFFFFFFFF, 32'h10C, 0, 0);
    chk("ones_illegal", 128'({b1.out_illegal, b0.out_illegal, b1.out_instr}), 128'({1'b1, 1'b1, INSTR_BAD_INSTR}));
    step(0, 0, 0, 1, 0);

    for (int i = 0; i < DEPTH; i++) step(1, gen_word(), 32'h200 + 32'(i * 4), 0, 0);
    chk("full_count", 128'(b1.count), 128'(DEPTH));
    chk("full_in_ready", 128'(b1.in_ready), 128'(0));
    step(1, 32'h00A00113, 32'h210, 0, 0);
    chk("held_count", 128'(b1.count), 128'(DEPTH));
    step(1, 32'h00A00113, 32'h210, 1, 0);
    chk("pop_reopens", 128'({b1.count, b1.in_ready}), 128'({3'd3, 1'b1}));
    step(1, 32'h00A00113, 32'h210, 0, 0);
    chk("refill_count", 128'(b1.count), 128'(DEPTH));
    repeat (DEPTH) step(0, 0, 0, 1, 0);
    chk("drained", 128'({b1.count, b1.out_valid}), 128'(0));

    step(1, gen_word(), 32'h300, 0, 0);
    step(1, gen_word(), 32'h304, 0, 0);
    step(1, gen_word(), 32'h308, 1, 0);
    chk("push_pop_count2", 128'(b1.count), 128'(2));
    step(1, gen_word(), 32'h30C, 0, 0);
    chk("count3", 128'(b1.count), 128'(3));
    step(1, 32'h00500093, 32'h310, 0, 1);
    chk("flush_empty", 128'({b1.count, b1.out_valid, b0.count}), 128'(0));
    step(1, 32'h00700193, 32'h314, 0, 0);
    step(0, 0, 0, 1, 0);

    pc = 32'h1000;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset(1);
      step($urandom_range(0, 3) != 0, gen_word(), pc, $urandom_range(0, 2) != 0,
           $urandom_range(0, 59) == 0);
      pc = pc + 32'd4;
    end
    repeat (DEPTH + 1) step(0, 0, 0, 1, 0);
    chk("final_empty", 128'({b1.count, q1.size() == 0}), 128'({3'd0, 1'b1}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
